// File: rtl/xy_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary XY converter.
package xy_pkg;

    localparam int ACC_W = 10;

    localparam logic [ACC_W-1:0] W_HUND    = 10'd100;
    localparam logic [ACC_W-1:0] W_TENS    = 10'd10;
    localparam logic [3:0]       DIGIT_MAX = 4'd9;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUND = 2'd1;
    localparam logic [1:0] ST_TENS = 2'd2;
    localparam logic [1:0] ST_ONES = 2'd3;

    localparam int HUND_LSB = 8;
    localparam int TENS_LSB = 4;
    localparam int ONES_LSB = 0;

    function automatic logic bcd_bad(input logic [11:0] d);
        return (d[HUND_LSB +: 4] > DIGIT_MAX) ||
               (d[TENS_LSB +: 4] > DIGIT_MAX) ||
               (d[ONES_LSB +: 4] > DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_lane.sv
// One coordinate lane: latched digit counters, repeated-addition accumulator,
// and the saturating/wrapping output register.
module bcd_lane
    import xy_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             RST,
    input  state_t           state,
    input  logic             load,
    input  logic             clr_ovf,
    input  logic [11:0]      bcd,
    output logic [OUT_W-1:0] pos,
    output logic             ovf,
    output logic             more
);

    localparam logic [31:0] OUT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

    logic [3:0]       cnt_h;
    logic [3:0]       cnt_t;
    logic [3:0]       ones;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [31:0]      sum32;
    logic             sum_ovf;

    assign sum     = acc + ACC_W'(ones);
    assign sum32   = 32'(sum);
    assign sum_ovf = sum32 > OUT_MAX;

    // The FSM stays in a phase while any lane still has more than one add left.
    always_comb begin
        more = 1'b0;
        if (state == ST_HUND) begin
            more = cnt_h > 4'd1;
        end else if (state == ST_TENS) begin
            more = cnt_t > 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_h <= '0;
            cnt_t <= '0;
            ones  <= '0;
            acc   <= '0;
            pos   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                cnt_h <= bcd[HUND_LSB +: 4];
                cnt_t <= bcd[TENS_LSB +: 4];
                ones  <= bcd[ONES_LSB +: 4];
                acc   <= '0;
            end else begin
                case (state)
                    ST_HUND: begin
                        if (cnt_h != 4'd0) begin
                            acc   <= acc + W_HUND;
                            cnt_h <= cnt_h - 4'd1;
                        end
                    end
                    ST_TENS: begin
                        if (cnt_t != 4'd0) begin
                            acc   <= acc + W_TENS;
                            cnt_t <= cnt_t - 4'd1;
                        end
                    end
                    ST_ONES: begin
                        ovf <= sum_ovf;
                        pos <= (sum_ovf && SAT_EN) ? {OUT_W{1'b1}} : sum32[OUT_W-1:0];
                    end
                    default: ;
                endcase
            end
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_to_xy.sv
// Decimal-entry front end: converts 3-digit BCD X/Y to binary with a
// start/busy/done handshake; both lanes run in lock-step under one FSM.
//
//   state | meaning
//   IDLE  | waiting for start; rejects requests with a digit > 9
//   HUND  | adding 100 per remaining hundreds count
//   TENS  | adding 10 per remaining tens count
//   ONES  | adding ones digit, registering result and flags, pulsing done
module bcd_to_xy
    import xy_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [11:0]      bcd_x,
    input  logic [11:0]      bcd_y,
    output logic [OUT_W-1:0] Xpos,
    output logic [OUT_W-1:0] Ypos,
    output logic             busy,
    output logic             done,
    output logic             ovf_x,
    output logic             ovf_y,
    output logic             err
);

    state_t state;
    logic   bad;
    logic   accept;
    logic   reject;
    logic   more_x;
    logic   more_y;

    assign bad    = bcd_bad(bcd_x) || bcd_bad(bcd_y);
    assign accept = (state == ST_IDLE) && start && !bad;
    assign reject = (state == ST_IDLE) && start && bad;
    assign busy   = state != ST_IDLE;

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_HUND;
                    end else if (reject) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                ST_HUND: begin
                    if (!(more_x || more_y)) state <= ST_TENS;
                end
                ST_TENS: begin
                    if (!(more_x || more_y)) state <= ST_ONES;
                end
                ST_ONES: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bcd_lane #(.OUT_W(OUT_W), .SAT_EN(SAT_EN)) u_lane_x (
        .clk     (clk),
        .RST     (RST),
        .state   (state),
        .load    (accept),
        .clr_ovf (reject),
        .bcd     (bcd_x),
        .pos     (Xpos),
        .ovf     (ovf_x),
        .more    (more_x)
    );

    bcd_lane #(.OUT_W(OUT_W), .SAT_EN(SAT_EN)) u_lane_y (
        .clk     (clk),
        .RST     (RST),
        .state   (state),
        .load    (accept),
        .clr_ovf (reject),
        .bcd     (bcd_y),
        .pos     (Ypos),
        .ovf     (ovf_y),
        .more    (more_y)
    );

endmodule

// File: tb/tb_bcd_to_xy.sv
// Bench for bcd_to_xy: saturating and wrapping instances against a
// cycle-level decimal model, plus literal expectations per directed job.
module tb_bcd_to_xy;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [11:0] bcd_x;
    logic [11:0] bcd_y;

    logic [7:0] Xpos, Ypos, Xpos_w, Ypos_w;
    logic       busy, done, ovf_x, ovf_y, err;
    logic       busy_w, done_w, ovf_x_w, ovf_y_w, err_w;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bcd_to_xy #(.OUT_W(8), .SAT_EN(1'b1)) dut (
        .clk(clk), .RST(RST), .start(start), .bcd_x(bcd_x), .bcd_y(bcd_y),
        .Xpos(Xpos), .Ypos(Ypos), .busy(busy), .done(done),
        .ovf_x(ovf_x), .ovf_y(ovf_y), .err(err)
    );

    bcd_to_xy #(.OUT_W(8), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .RST(RST), .start(start), .bcd_x(bcd_x), .bcd_y(bcd_y),
        .Xpos(Xpos_w), .Ypos(Ypos_w), .busy(busy_w), .done(done_w),
        .ovf_x(ovf_x_w), .ovf_y(ovf_y_w), .err(err_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- decimal model ----------------
    int m_left = 0;
    int m_x = 0, m_y = 0, m_xw = 0, m_yw = 0;
    bit m_ox = 0, m_oy = 0, m_err = 0, m_done = 0;
    int p_x, p_y, p_xw, p_yw;
    bit p_ox, p_oy;

    function automatic int dec3(input logic [11:0] d);
        return 100 * int'(d[11:8]) + 10 * int'(d[7:4]) + int'(d[3:0]);
    endfunction

    function automatic bit dbad(input logic [11:0] d);
        return (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    always @(posedge clk) begin
        int vx, vy, k1, k2;
        m_done = 1'b0;
        if (RST) begin
            m_left = 0; m_x = 0; m_y = 0; m_xw = 0; m_yw = 0;
            m_ox = 0; m_oy = 0; m_err = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_err = 1'b0;
                m_x = p_x; m_y = p_y; m_xw = p_xw; m_yw = p_yw;
                m_ox = p_ox; m_oy = p_oy;
            end
        end else if (start) begin
            if (dbad(bcd_x) || dbad(bcd_y)) begin
                m_done = 1'b1; m_err = 1'b1; m_ox = 1'b0; m_oy = 1'b0;
            end else begin
                vx = dec3(bcd_x);
                vy = dec3(bcd_y);
                p_ox = vx > 255;  p_oy = vy > 255;
                p_x  = p_ox ? 255 : vx;
                p_y  = p_oy ? 255 : vy;
                p_xw = vx % 256;  p_yw = vy % 256;
                k1 = (bcd_x[11:8] > bcd_y[11:8]) ? int'(bcd_x[11:8]) : int'(bcd_y[11:8]);
                k2 = (bcd_x[7:4]  > bcd_y[7:4])  ? int'(bcd_x[7:4])  : int'(bcd_y[7:4]);
                if (k1 < 1) k1 = 1;
                if (k2 < 1) k2 = 1;
                m_left = k1 + k2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Xpos",    Xpos,    m_x);
            chk("Ypos",    Ypos,    m_y);
            chk("busy",    busy,    m_left > 0);
            chk("done",    done,    m_done);
            chk("ovf_x",   ovf_x,   m_ox);
            chk("ovf_y",   ovf_y,   m_oy);
            chk("err",     err,     m_err);
            chk("Xpos_w",  Xpos_w,  m_xw);
            chk("Ypos_w",  Ypos_w,  m_yw);
            chk("done_w",  done_w,  m_done);
            chk("busy_w",  busy_w,  m_left > 0);
            chk("ovf_x_w", ovf_x_w, m_ox);
            chk("ovf_y_w", ovf_y_w, m_oy);
            chk("err_w",   err_w,   m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic go(input logic [11:0] x, input logic [11:0] y);
        bcd_x = x;
        bcd_y = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcd_x = 12'h999;
        bcd_y = 12'h999;
    endtask

    // Counts edges after the sampling edge until done; poke re-asserts start mid-job.
    task automatic wait_done(input int exp_lat, input int poke, input string nm);
        int cyc;
        int nb;
        cyc = 0;
        nb  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nb++;
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, cyc, exp_lat);
        chk({nm, "_busy_cycles"}, nb, exp_lat);
    endtask

    initial begin
        int nd;
        RST = 1'b1; start = 1'b0; bcd_x = '0; bcd_y = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_Xpos", Xpos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err,  0);
        RST = 1'b0;
        @(negedge clk);

        go(12'h123, 12'h045); wait_done(6, -1, "j123");
        chk("j123_x", Xpos, 123); chk("j123_y", Ypos, 45);
        chk("j123_ovf", ovf_x, 0); chk("j123_err", err, 0);
        @(negedge clk);

        go(12'h1A0, 12'h045); wait_done(0, -1, "jerr");
        chk("jerr_err", err, 1); chk("jerr_x", Xpos, 123); chk("jerr_y", Ypos, 45);
        @(negedge clk);

        go(12'h000, 12'h000); wait_done(3, -1, "j000");
        chk("j000_x", Xpos, 0); chk("j000_y", Ypos, 0); chk("j000_err", err, 0);
        @(negedge clk);

        go(12'h999, 12'h255); wait_done(19, -1, "j999");
        chk("j999_x", Xpos, 255); chk("j999_ovfx", ovf_x, 1);
        chk("j999_y", Ypos, 255); chk("j999_ovfy", ovf_y, 0);
        chk("j999_xwrap", Xpos_w, 231); chk("j999_ovfx_w", ovf_x_w, 1);
        @(negedge clk);

        go(12'h0F0, 12'h001); wait_done(0, -1, "jerr2");
        chk("jerr2_ovfx", ovf_x, 0); chk("jerr2_x", Xpos, 255);
        @(negedge clk);

        go(12'h340, 12'h120); wait_done(8, 2, "j340");
        chk("j340_x", Xpos, 255); chk("j340_xw", Xpos_w, 84); chk("j340_y", Ypos, 120);
        go(12'h067, 12'h089); wait_done(10, -1, "jdonestart");
        chk("j067_x", Xpos, 67); chk("j089_y", Ypos, 89);
        @(negedge clk);

        go(12'h250, 12'h199);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        chk("abort_x", Xpos, 0); chk("abort_y", Ypos, 0); chk("abort_busy", busy, 0);
        nd = 0;
        repeat (15) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", nd, 0);

        go(12'h250, 12'h199); wait_done(12, -1, "j250");
        chk("j250_x", Xpos, 250); chk("j250_y", Ypos, 199);
        chk("j250_ovf", ovf_x | ovf_y, 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
